pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the RV32I core: merges per-stage stall requests into the
//  6-bit stall vector (PC,IF,ID,EX,MEM,WB) and sequences trap/mret flushes and redirects.

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the RV32I core.
// Merges per-stage stall requests into a 6-bit stall vector (bit0 PC .. bit5 WB),
// sequences trap/mret flushes with a redirect PC, holds off new exceptions for a
// short refill window after each flush, and traps on a MEM stall that never ends.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned REFILL_CYCLES = 2,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 11,
  parameter logic [31:0] EXC_MRET      = 32'h0000_000E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned RW = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);

  typedef enum logic [0:0] {
    StIdle,
    StRefill
  } state_e;

  state_e           state_q;
  logic [RW-1:0]    refill_q;
  logic [CNT_W-1:0] wd_q;

  logic [5:0] req_stall;
  logic       wd_fire;
  logic       exc_take;
  logic       flush_int;

  // Priority-encode stall requests, decide trap/watchdog events and drive the outputs.
  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem)     req_stall = 6'b011111;
    else if (stallreq_ex) req_stall = 6'b001111;
    else if (stallreq_id) req_stall = 6'b000111;
    else if (stallreq_if) req_stall = 6'b000011;

    wd_fire  = 1'b0;
    exc_take = 1'b0;
    if (state_q == StIdle) begin
      // Counter holds the number of earlier consecutive MEM-stall cycles.
      wd_fire  = stallreq_mem && (wd_q == CNT_W'(STALL_TIMEOUT - 1));
      // An exception waits while MEM is stalled; the stall vector then holds it in place.
      exc_take = (excepttype_i != 32'h0) && !stallreq_mem;
    end
    flush_int = wd_fire || exc_take;

    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = 32'h0;
    timeout_o = 1'b0;
    if (!rst) begin
      if (wd_fire) begin
        flush     = 1'b1;
        new_pc    = mtvec_i;
        timeout_o = 1'b1;
      end else if (exc_take) begin
        flush  = 1'b1;
        new_pc = (excepttype_i == EXC_MRET) ? mepc_i : mtvec_i;
      end else begin
        stall = req_stall;
      end
    end
  end

  // Sequencer state, refill window countdown and MEM-stall watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      refill_q <= '0;
      wd_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_int) begin
            state_q  <= StRefill;
            refill_q <= RW'(REFILL_CYCLES);
            wd_q     <= '0;
          end else if (stallreq_mem) begin
            wd_q <= wd_q + CNT_W'(1);
          end else begin
            wd_q <= '0;
          end
        end
        StRefill: begin
          wd_q <= '0;
          if (refill_q <= RW'(1)) begin
            state_q  <= StIdle;
            refill_q <= '0;
          end else begin
            refill_q <= refill_q - RW'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          refill_q <= '0;
          wd_q     <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running wrap-around counters of stalled cycles and flush pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      if (stall != 6'b000000) perf_stall_q <= perf_stall_q + 32'h1;
      if (flush)              perf_flush_q <= perf_flush_q + 32'h1;
    end
  end

  assign perf_stall_cnt = rst ? 32'h0 : perf_stall_q;
  assign perf_flush_cnt = rst ? 32'h0 : perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process drives one cycle of inputs and
// queues the hand-computed outputs for that cycle; a monitor pops and checks at negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = 32'h0;
  logic [31:0] mtvec_i = 32'h100;
  logic [31:0] mepc_i = 32'h2004;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .timeout_o    (timeout_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s (test %0d): got %h expected %h", name, tag, act, req);
    end
  endtask

  // One cycle of stimulus; req = {mem, ex, id, if}.
  task automatic step(input logic r, input logic [3:0] req, input logic [31:0] exc,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic et, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_mem = req[3];
    stallreq_ex  = req[2];
    stallreq_id  = req[1];
    stallreq_if  = req[0];
    excepttype_i = exc;
    e.tag = tag; e.rst = r; e.stall = es; e.flush = ef; e.pc = ep; e.tmo = et;
    exp_q.push_back(e);
  endtask

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] m_sc = 32'h0;
  logic [31:0] m_fc = 32'h0;
`endif

  // Monitor: compare the DUT outputs of this cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", e.tag, {26'h0, stall}, {26'h0, e.stall});
      chk("flush", e.tag, {31'h0, flush}, {31'h0, e.flush});
      chk("new_pc", e.tag, new_pc, e.pc);
      chk("timeout", e.tag, {31'h0, timeout_o}, {31'h0, e.tmo});
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_stall", e.tag, perf_stall_cnt, e.rst ? 32'h0 : m_sc);
      chk("perf_flush", e.tag, perf_flush_cnt, e.rst ? 32'h0 : m_fc);
      if (e.rst) begin
        m_sc = 32'h0;
        m_fc = 32'h0;
      end else begin
        if (e.stall != 6'b0) m_sc = m_sc + 32'h1;
        if (e.flush) m_fc = m_fc + 32'h1;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset with busy inputs: all outputs must read 0.
    step(1'b1, 4'b1111, 32'h8, 6'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b1, 4'b1111, 32'hE, 6'b0, 1'b0, 32'h0, 1'b0, 0);

    // Stall priority encoding.
    step(1'b0, 4'b0110, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 4'b0001, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 4'b0011, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 4'b1111, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 1);

    // Trap held 4 cycles: flush, two refill cycles (stall honoured), flush again.
    step(1'b0, 4'b0000, 32'h8, 6'b000000, 1'b1, 32'h100, 1'b0, 2);
    step(1'b0, 4'b0100, 32'h8, 6'b001111, 1'b0, 32'h0, 1'b0, 2);
    step(1'b0, 4'b0000, 32'h8, 6'b000000, 1'b0, 32'h0, 1'b0, 2);
    step(1'b0, 4'b0000, 32'h8, 6'b000000, 1'b1, 32'h100, 1'b0, 2);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 2);

    // mret redirects to mepc.
    step(1'b0, 4'b0000, 32'hE, 6'b000000, 1'b1, 32'h2004, 1'b0, 3);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 3);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 3);

    // Exception deferred behind MEM stall, taken when it drops.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 32'h8, 6'b011111, 1'b0, 32'h0, 1'b0, 4);
    step(1'b0, 4'b0000, 32'h8, 6'b000000, 1'b1, 32'h100, 1'b0, 4);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 4);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 4);

    // Watchdog fires on the 1024th consecutive MEM-stall cycle.
    for (int i = 1; i <= 1023; i++) step(1'b0, 4'b1000, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 5);
    step(1'b0, 4'b1000, 32'h0, 6'b000000, 1'b1, 32'h100, 1'b1, 5);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 5);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 5);
    // 1023-cycle burst then drop: no timeout, counter restarts.
    for (int i = 1; i <= 1023; i++) step(1'b0, 4'b1000, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 5);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 5);
    step(1'b0, 4'b1000, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 5);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 5);

    // Reset during refill: outputs 0, then next exception taken at once.
    step(1'b0, 4'b0000, 32'h8, 6'b000000, 1'b1, 32'h100, 1'b0, 6);
    step(1'b1, 4'b0100, 32'h8, 6'b000000, 1'b0, 32'h0, 1'b0, 6);
    step(1'b0, 4'b0000, 32'hE, 6'b000000, 1'b1, 32'h2004, 1'b0, 6);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 6);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 6);
    // Reset mid-count clears the watchdog.
    for (int i = 0; i < 600; i++) step(1'b0, 4'b1000, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 7);
    step(1'b1, 4'b1000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 7);
    for (int i = 0; i < 1023; i++) step(1'b0, 4'b1000, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0, 7);
    step(1'b0, 4'b0000, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0, 7);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
